// File: rtl/spi_pixel_loader_pkg.sv
// spi_pixel_loader_pkg
// Shared constants and types for the SPI pixel loader: command opcodes,
// write-address width and the frame-decoder state encoding.
package spi_pixel_loader_pkg;

  localparam int ADDR_W = 9;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_CLEAR = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA,
    ST_DISCARD,
    ST_CLEAR
  } state_t;

endpackage

// File: rtl/spi_pixel_loader_if.sv
// spi_pixel_loader_if
// Bundles the host SPI pins and the byte-write bus into the LED output stage.
//   spi_sclk/spi_mosi/spi_cs_n : host SPI (mode 0), asynchronous to clk
//   spi_miso                   : echo data (only with SPI_PIXEL_LOADER_MISO_EN)
//   address_out/data_out       : write address / 8-bit brightness
//   write_strobe_out           : one-cycle write pulse
//   frame_done/busy/addr_overflow : status pulses and CLEAR-in-progress flag
// modport slave  : the loader
// modport master : the host / environment side
interface spi_pixel_loader_if;
  import spi_pixel_loader_pkg::*;

  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_cs_n;
`ifdef SPI_PIXEL_LOADER_MISO_EN
  logic              spi_miso;
`endif
  logic [ADDR_W-1:0] address_out;
  logic [7:0]        data_out;
  logic              write_strobe_out;
  logic              frame_done;
  logic              busy;
  logic              addr_overflow;

  modport slave (
    input  spi_sclk, spi_mosi, spi_cs_n,
`ifdef SPI_PIXEL_LOADER_MISO_EN
    output spi_miso,
`endif
    output address_out, data_out, write_strobe_out, frame_done, busy, addr_overflow
  );

  modport master (
    output spi_sclk, spi_mosi, spi_cs_n,
`ifdef SPI_PIXEL_LOADER_MISO_EN
    input  spi_miso,
`endif
    input  address_out, data_out, write_strobe_out, frame_done, busy, addr_overflow
  );

endinterface

// File: rtl/spi_pixel_loader_sync_edge.sv
// spi_sync_edge
// Two-flop synchronizer followed by an edge-detect register.
//   i_clk, i_rst_n : system clock, async active-low reset
//   i_async        : asynchronous input
//   o_level        : synchronised level, aligned with o_rise/o_fall
//   o_rise/o_fall  : one-cycle registered edge pulses
// P_RST_VAL sets the idle level so reset release does not fake an edge.
module spi_sync_edge #(
  parameter logic P_RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta, r_sync, r_prev, r_rise, r_fall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= P_RST_VAL;
      r_sync <= P_RST_VAL;
      r_prev <= P_RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
      r_fall <= ~r_sync & r_prev;
    end
  end

  // r_prev updates on the same edge as the pulses, so level and edges line up
  assign o_level = r_prev;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/spi_pixel_loader.sv
// spi_pixel_loader
// Receives pixel frames over SPI mode 0 (MSB first), decodes a WRITE/CLEAR
// header and issues single-cycle byte writes into the LED value memory.
//   i_clk   : system clock (>= 4x spi_sclk)
//   i_rst_n : asynchronous active-low reset
//   bus     : spi_pixel_loader_if.slave (SPI pins, write bus, status)
// Parameter OUTPUTS_TOTAL: number of writable LED values.
// Macro SPI_PIXEL_LOADER_MISO_EN: adds the MISO echo of the previous byte.
//
// state      | meaning
// IDLE       | waiting for cs_n fall
// CMD        | receiving command byte
// ADDR_HI    | receiving pointer MSB (bit 0)
// ADDR_LO    | receiving pointer bits 7:0
// DATA       | each byte written at pointer, pointer increments
// DISCARD    | ignoring bytes until cs_n rises
// CLEAR      | zeroing addresses 0..OUTPUTS_TOTAL-1, one per clk
module spi_pixel_loader
  import spi_pixel_loader_pkg::*;
#(
  parameter int OUTPUTS_TOTAL = 128
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  spi_pixel_loader_if.slave bus
);

  localparam logic [ADDR_W:0]   LP_TOTAL = (ADDR_W+1)'(OUTPUTS_TOTAL);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(OUTPUTS_TOTAL - 1);

  logic w_sclk_rise, w_sclk_fall, w_sclk_level;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_unused;

  spi_sync_edge #(.P_RST_VAL(1'b0)) u_sync_sclk (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(bus.spi_sclk),
    .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));

  spi_sync_edge #(.P_RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(bus.spi_mosi),
    .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));

  spi_sync_edge #(.P_RST_VAL(1'b1)) u_sync_cs (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(bus.spi_cs_n),
    .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall));

  // Byte assembly: a partial byte dies whenever cs_n is high
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_byte_vld;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_byte_vld <= 1'b0;
    end else begin
      r_byte_vld <= 1'b0;
      if (w_cs_level) begin
        r_bit_cnt <= '0;
      end else if (w_sclk_rise) begin
        r_shift    <= {r_shift[6:0], w_mosi};
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        r_byte_vld <= (r_bit_cnt == 3'd7);
      end
    end
  end

  // Frame decoder
  state_t            r_state, w_next_state;
  logic [ADDR_W-1:0] r_ptr, w_next_ptr;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [7:0]        r_data, w_data;
  logic              r_strobe, w_strobe;
  logic              r_done, w_done;
  logic              r_busy, w_busy;
  logic              r_ovf, w_ovf;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_ptr    <= w_next_ptr;
      r_addr   <= w_addr;
      r_data   <= w_data;
      r_strobe <= w_strobe;
      r_done   <= w_done;
      r_busy   <= w_busy;
      r_ovf    <= w_ovf;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_ptr   = r_ptr;
    w_addr       = r_addr;
    w_data       = r_data;
    w_strobe     = 1'b0;
    w_done       = 1'b0;
    w_busy       = 1'b0;
    w_ovf        = 1'b0;
    // cs_n rise outranks a byte completing in the same cycle
    unique case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) w_next_state = ST_CMD;
      end
      ST_CMD: begin
        if (w_cs_rise) w_next_state = ST_IDLE;
        else if (r_byte_vld) begin
          if (r_shift == CMD_WRITE) begin
            w_next_state = ST_ADDR_HI;
          end else if (r_shift == CMD_CLEAR) begin
            w_next_state = ST_CLEAR;
            w_next_ptr   = '0;
          end else begin
            w_next_state = ST_DISCARD;
          end
        end
      end
      ST_ADDR_HI: begin
        if (w_cs_rise) w_next_state = ST_IDLE;
        else if (r_byte_vld) begin
          w_next_ptr   = {r_shift[0], r_ptr[7:0]};
          w_next_state = ST_ADDR_LO;
        end
      end
      ST_ADDR_LO: begin
        if (w_cs_rise) w_next_state = ST_IDLE;
        else if (r_byte_vld) begin
          w_next_ptr   = {r_ptr[8], r_shift};
          w_next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_cs_rise) begin
          w_next_state = ST_IDLE;
          w_done       = 1'b1;
        end else if (r_byte_vld) begin
          if ({1'b0, r_ptr} < LP_TOTAL) begin
            w_strobe = 1'b1;
            w_addr   = r_ptr;
            w_data   = r_shift;
          end else begin
            w_ovf = 1'b1;
          end
          w_next_ptr = r_ptr + 9'd1;
        end
      end
      ST_DISCARD: begin
        if (w_cs_rise) w_next_state = ST_IDLE;
      end
      ST_CLEAR: begin
        // ignores cs_n and SPI bytes until the sweep is finished
        w_strobe   = 1'b1;
        w_busy     = 1'b1;
        w_addr     = r_ptr;
        w_data     = 8'h00;
        w_next_ptr = r_ptr + 9'd1;
        if (r_ptr == LP_LAST) begin
          w_next_ptr   = '0;
          w_next_state = w_cs_level ? ST_IDLE : ST_DISCARD;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign bus.address_out      = r_addr;
  assign bus.data_out         = r_data;
  assign bus.write_strobe_out = r_strobe;
  assign bus.frame_done       = r_done;
  assign bus.busy             = r_busy;
  assign bus.addr_overflow    = r_ovf;

`ifdef SPI_PIXEL_LOADER_MISO_EN
  // Echo of the previous completed byte; the bit counter already points at
  // the next bit to be sampled, so it indexes the echo directly.
  logic [7:0] r_echo;
  logic       r_miso;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_echo <= '0;
      r_miso <= 1'b0;
    end else if (w_cs_level) begin
      r_echo <= '0;
      r_miso <= 1'b0;
    end else begin
      if (r_byte_vld) r_echo <= r_shift;
      if (w_sclk_fall) r_miso <= r_echo[3'd7 - r_bit_cnt];
    end
  end

  assign bus.spi_miso = r_miso;
  assign w_unused     = w_mosi_rise ^ w_mosi_fall ^ w_sclk_level;
`else
  assign w_unused     = w_mosi_rise ^ w_mosi_fall ^ w_sclk_fall ^ w_sclk_level;
`endif

endmodule

// File: tb/tb_spi_pixel_loader.sv
`timescale 1ns/1ps
module tb_spi_pixel_loader;
  import spi_pixel_loader_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_pixel_loader_if bus();

  spi_pixel_loader #(.OUTPUTS_TOTAL(128)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_e0 = 0;
  logic [7:0] last_miso = 8'h00;

  logic [8:0] q_addr[$];
  logic [7:0] q_data[$];
  int         q_cyc[$];
  int ovf_cnt = 0, fd_cnt = 0, busy_cnt = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.write_strobe_out) begin
        q_addr.push_back(bus.address_out);
        q_data.push_back(bus.data_out);
        q_cyc.push_back(cyc);
      end
      if (bus.addr_overflow) ovf_cnt++;
      if (bus.frame_done) fd_cnt++;
      if (bus.busy) busy_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    q_addr.delete(); q_data.delete(); q_cyc.delete();
    ovf_cnt = 0; fd_cnt = 0; busy_cnt = 0;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      @(posedge clk); #2 bus.spi_mosi = b[i];
      repeat (3) @(posedge clk);
      #2;
`ifdef SPI_PIXEL_LOADER_MISO_EN
      last_miso = {last_miso[6:0], bus.spi_miso};
`endif
      bus.spi_sclk = 1'b1;
      last_e0 = cyc + 1;
      repeat (4) @(posedge clk);
      #2 bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b);
    spi_bits(b, 8);
  endtask

  task automatic cs_low();
    @(posedge clk); #2 bus.spi_cs_n = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic cs_high();
    @(posedge clk); #2 bus.spi_cs_n = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_reset();
    bus.spi_sclk = 1'b0; bus.spi_mosi = 1'b0; bus.spi_cs_n = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (bus.address_out !== 9'd0) begin n_fail++; $display("FAIL reset_addr got %h exp 000", bus.address_out); end
    n_chk++; if (bus.data_out !== 8'd0) begin n_fail++; $display("FAIL reset_data got %h exp 00", bus.data_out); end
    n_chk++; if (bus.write_strobe_out !== 1'b0) begin n_fail++; $display("FAIL reset_strobe got %b exp 0", bus.write_strobe_out); end
    n_chk++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.frame_done); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    n_chk++; if (bus.addr_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", bus.addr_overflow); end
`ifdef SPI_PIXEL_LOADER_MISO_EN
    n_chk++; if (bus.spi_miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso got %b exp 0", bus.spi_miso); end
`endif
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_write();
    int e0;
    clear_mon();
    cs_low();
    spi_byte(8'h01); spi_byte(8'h00); spi_byte(8'h05);
    spi_byte(8'hAA); e0 = last_e0;
    spi_byte(8'h55);
    cs_high();
    n_chk++; if (q_addr.size() !== 2) begin n_fail++; $display("FAIL write_count got %0d exp 2", q_addr.size()); end
    if (q_addr.size() >= 2) begin
      n_chk++; if (q_addr[0] !== 9'h005 || q_data[0] !== 8'hAA) begin n_fail++; $display("FAIL write_first got %h/%h exp 005/aa", q_addr[0], q_data[0]); end
      n_chk++; if (q_addr[1] !== 9'h006 || q_data[1] !== 8'h55) begin n_fail++; $display("FAIL write_second got %h/%h exp 006/55", q_addr[1], q_data[1]); end
      n_chk++; if (q_cyc[0] - e0 !== 4) begin n_fail++; $display("FAIL write_latency got %0d exp 4", q_cyc[0] - e0); end
    end
    n_chk++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL write_frame_done got %0d exp 1", fd_cnt); end
    n_chk++; if (ovf_cnt !== 0) begin n_fail++; $display("FAIL write_ovf got %0d exp 0", ovf_cnt); end
    n_chk++; if (bus.address_out !== 9'h006 || bus.data_out !== 8'h55) begin n_fail++; $display("FAIL write_hold got %h/%h exp 006/55", bus.address_out, bus.data_out); end
  endtask

  task automatic test_overflow();
    clear_mon();
    cs_low();
    spi_byte(8'h01); spi_byte(8'h00); spi_byte(8'h7F);
    spi_byte(8'hA1); spi_byte(8'hB2); spi_byte(8'hC3);
    cs_high();
    n_chk++; if (q_addr.size() !== 1) begin n_fail++; $display("FAIL ovf_write_count got %0d exp 1", q_addr.size()); end
    if (q_addr.size() >= 1) begin
      n_chk++; if (q_addr[0] !== 9'h07F || q_data[0] !== 8'hA1) begin n_fail++; $display("FAIL ovf_write got %h/%h exp 07f/a1", q_addr[0], q_data[0]); end
    end
    n_chk++; if (ovf_cnt !== 2) begin n_fail++; $display("FAIL ovf_pulses got %0d exp 2", ovf_cnt); end
    n_chk++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL ovf_frame_done got %0d exp 1", fd_cnt); end
  endtask

  task automatic test_wrap();
    clear_mon();
    cs_low();
    spi_byte(8'h01); spi_byte(8'h01); spi_byte(8'hFF);
    spi_byte(8'h11); spi_byte(8'h22);
    cs_high();
    n_chk++; if (ovf_cnt !== 1) begin n_fail++; $display("FAIL wrap_ovf got %0d exp 1", ovf_cnt); end
    n_chk++; if (q_addr.size() !== 1) begin n_fail++; $display("FAIL wrap_count got %0d exp 1", q_addr.size()); end
    if (q_addr.size() >= 1) begin
      n_chk++; if (q_addr[0] !== 9'h000 || q_data[0] !== 8'h22) begin n_fail++; $display("FAIL wrap_write got %h/%h exp 000/22", q_addr[0], q_data[0]); end
    end
  endtask

  task automatic test_clear();
    int e0;
    int bad;
    clear_mon();
    cs_low();
    spi_byte(8'h02); e0 = last_e0;
    @(posedge clk); #2 bus.spi_cs_n = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL clear_timeout busy got %b exp 0", bus.busy); end
    n_chk++; if (q_addr.size() !== 128) begin n_fail++; $display("FAIL clear_count got %0d exp 128", q_addr.size()); end
    if (q_addr.size() == 128) begin
      bad = 0;
      for (int i = 0; i < 128; i++)
        if (q_addr[i] !== 9'(i) || q_data[i] !== 8'h00 || q_cyc[i] !== q_cyc[0] + i) bad++;
      n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL clear_sequence got %0d bad entries exp 0", bad); end
      n_chk++; if (q_cyc[0] - e0 !== 5) begin n_fail++; $display("FAIL clear_first_latency got %0d exp 5", q_cyc[0] - e0); end
    end
    n_chk++; if (busy_cnt !== 128) begin n_fail++; $display("FAIL clear_busy_cycles got %0d exp 128", busy_cnt); end
    n_chk++; if (fd_cnt !== 0) begin n_fail++; $display("FAIL clear_frame_done got %0d exp 0", fd_cnt); end
  endtask

  task automatic test_clear_hold();
    clear_mon();
    cs_low();
    spi_byte(8'h02);
    repeat (150) @(posedge clk);
    spi_byte(8'h01); spi_byte(8'h00); spi_byte(8'h03); spi_byte(8'h11);
    cs_high();
    n_chk++; if (q_addr.size() !== 128) begin n_fail++; $display("FAIL clear_hold_count got %0d exp 128", q_addr.size()); end
    n_chk++; if (fd_cnt !== 0 || ovf_cnt !== 0) begin n_fail++; $display("FAIL clear_hold_pulses got fd %0d ovf %0d exp 0 0", fd_cnt, ovf_cnt); end
  endtask

  task automatic test_unknown();
    clear_mon();
    cs_low();
    spi_byte(8'h7E); spi_byte(8'h11); spi_byte(8'h22); spi_byte(8'h33); spi_byte(8'h44);
    cs_high();
    n_chk++; if (q_addr.size() !== 0) begin n_fail++; $display("FAIL unknown_strobes got %0d exp 0", q_addr.size()); end
    n_chk++; if (fd_cnt !== 0 || ovf_cnt !== 0) begin n_fail++; $display("FAIL unknown_pulses got fd %0d ovf %0d exp 0 0", fd_cnt, ovf_cnt); end
    clear_mon();
    cs_low();
    spi_byte(8'h01); spi_byte(8'h00); spi_byte(8'h20); spi_byte(8'h3C);
    cs_high();
    n_chk++; if (q_addr.size() !== 1) begin n_fail++; $display("FAIL after_unknown_count got %0d exp 1", q_addr.size()); end
    if (q_addr.size() >= 1) begin
      n_chk++; if (q_addr[0] !== 9'h020 || q_data[0] !== 8'h3C) begin n_fail++; $display("FAIL after_unknown_write got %h/%h exp 020/3c", q_addr[0], q_data[0]); end
    end
    n_chk++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL after_unknown_done got %0d exp 1", fd_cnt); end
  endtask

  task automatic test_partial_reset();
    clear_mon();
    cs_low();
    spi_byte(8'h01); spi_byte(8'h00); spi_byte(8'h10);
    spi_bits(8'hD5, 5);
    cs_high();
    n_chk++; if (q_addr.size() !== 0) begin n_fail++; $display("FAIL partial_strobes got %0d exp 0", q_addr.size()); end
    n_chk++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL partial_done got %0d exp 1", fd_cnt); end
    cs_low();
    spi_byte(8'h01); spi_byte(8'h00); spi_byte(8'h11); spi_byte(8'h77);
    spi_bits(8'hEE, 3);
    n_chk++; if (bus.address_out !== 9'h011 || bus.data_out !== 8'h77) begin n_fail++; $display("FAIL pre_reset_out got %h/%h exp 011/77", bus.address_out, bus.data_out); end
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.address_out !== 9'd0 || bus.data_out !== 8'd0) begin n_fail++; $display("FAIL async_reset_out got %h/%h exp 000/00", bus.address_out, bus.data_out); end
    n_chk++; if (bus.write_strobe_out !== 1'b0 || bus.frame_done !== 1'b0 || bus.busy !== 1'b0 || bus.addr_overflow !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_flags got %b%b%b%b exp 0000", bus.write_strobe_out, bus.frame_done, bus.busy, bus.addr_overflow);
    end
    bus.spi_cs_n = 1'b1; bus.spi_sclk = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    clear_mon();
    cs_low();
    spi_byte(8'h01); spi_byte(8'h00); spi_byte(8'h02); spi_byte(8'h99);
    cs_high();
    n_chk++; if (q_addr.size() !== 1) begin n_fail++; $display("FAIL post_reset_count got %0d exp 1", q_addr.size()); end
    if (q_addr.size() >= 1) begin
      n_chk++; if (q_addr[0] !== 9'h002 || q_data[0] !== 8'h99) begin n_fail++; $display("FAIL post_reset_write got %h/%h exp 002/99", q_addr[0], q_data[0]); end
    end
  endtask

`ifdef SPI_PIXEL_LOADER_MISO_EN
  task automatic test_miso();
    cs_low();
    spi_byte(8'h01);
    n_chk++; if (last_miso !== 8'h00) begin n_fail++; $display("FAIL miso_byte0 got %h exp 00", last_miso); end
    spi_byte(8'h00);
    n_chk++; if (last_miso !== 8'h01) begin n_fail++; $display("FAIL miso_byte1 got %h exp 01", last_miso); end
    spi_byte(8'h10);
    n_chk++; if (last_miso !== 8'h00) begin n_fail++; $display("FAIL miso_byte2 got %h exp 00", last_miso); end
    cs_high();
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_overflow();
    test_wrap();
    test_clear();
    test_clear_hold();
    test_unknown();
    test_partial_reset();
`ifdef SPI_PIXEL_LOADER_MISO_EN
    test_miso();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
